// File: rtl/mpadder_arbiter.sv
// Round-robin share of one mpadder between two level-request ports, with a done watchdog.
// req->ack is 3 cycles plus adder latency; a requester is held off simply by not being granted.
module mpadder_arbiter #(
   parameter int WIDTH   = 1027,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             sub0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             req1,
   input  logic             sub1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             ack0,
   output logic             ack1,
   output logic [WIDTH:0]   res,
   output logic             err,
   output logic             busy,
   output logic             adder_start,
   output logic             adder_sub,
   output logic [WIDTH-1:0] adder_a,
   output logic [WIDTH-1:0] adder_b,
   input  logic [WIDTH:0]   adder_res,
   input  logic             adder_done
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GUARD} state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t     state;
   state_t     state_nxt;
   logic       grant;
   logic       rr_last;
   logic       grant_vld;
   logic       grant_sel;
   logic       timed_out;
   logic [7:0] watchdog;

   // A done still high from the previous op must not let a new op start.
   always_comb begin
      grant_vld = (req0 | req1) & ~adder_done;
      grant_sel = (req0 & req1) ? ~rr_last : req1;
      timed_out = (watchdog == TIMEOUT_CNT);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_vld) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (adder_done || timed_out) state_nxt = RESP;
         RESP:    state_nxt = GUARD;
         GUARD:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // watchdog holds the number of cycles since adder_start, so the timeout
   // verdict lands exactly TIMEOUT cycles after the start pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant     <= 1'b0;
         rr_last   <= 1'b1;
         adder_sub <= 1'b0;
         adder_a   <= '0;
         adder_b   <= '0;
         watchdog  <= '0;
         res       <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  grant     <= grant_sel;
                  adder_sub <= grant_sel ? sub1 : sub0;
                  adder_a   <= grant_sel ? a1 : a0;
                  adder_b   <= grant_sel ? b1 : b0;
                  watchdog  <= '0;
                  err       <= 1'b0;
               end
            end
            ISSUE: watchdog <= watchdog + 8'd1;
            WAIT: begin
               watchdog <= watchdog + 8'd1;
               if (adder_done) begin
                  res <= adder_res;
                  err <= 1'b0;
               end else if (timed_out) begin
                  res <= '0;
                  err <= 1'b1;
               end
            end
            RESP:    rr_last <= grant;
            default: ;
         endcase
      end
   end

   always_comb begin
      adder_start = (state == ISSUE);
      ack0        = (state == RESP) & ~grant;
      ack1        = (state == RESP) & grant;
      busy        = (state != IDLE);
   end

endmodule

// File: tb/tb_mpadder_arbiter.sv
// Randomised and directed bench for mpadder_arbiter with a behavioural mpadder (done held 2 cycles).
module tb_mpadder_arbiter;
   localparam int W  = 1027;
   localparam int TO = 15;

   logic clk, reset;
   logic req0, sub0, req1, sub1;
   logic [W-1:0] a0, b0, a1, b1;
   logic ack0, ack1, err, busy, adder_start, adder_sub;
   logic [W:0] res, adder_res;
   logic [W-1:0] adder_a, adder_b;
   logic adder_done;

   int tests, fails;
   int model_delay;
   bit model_stuck;
   bit inj_done;
   int m_cnt, m_hold;
   logic [W:0] m_res;

   mpadder_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .sub0(sub0), .a0(a0), .b0(b0),
      .req1(req1), .sub1(sub1), .a1(a1), .b1(b1),
      .ack0(ack0), .ack1(ack1), .res(res), .err(err), .busy(busy),
      .adder_start(adder_start), .adder_sub(adder_sub),
      .adder_a(adder_a), .adder_b(adder_b),
      .adder_res(adder_res), .adder_done(adder_done)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #600000;
      $display("FAIL global_timeout: simulation still running, expected finish");
      $fatal(1);
   end

   function automatic logic [W:0] ref_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] xa, xb;
      xa = {1'b0, a};
      xb = {1'b0, b};
      return s ? (xa - xb) : (xa + xb);
   endfunction

   function automatic logic [W-1:0] rand_wide();
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < (W + 31) / 32; i++) v = {v[W-33:0], $urandom()};
      return v;
   endfunction

   // Behavioural mpadder: done rises model_delay cycles after start and stays 2 cycles.
   initial begin
      adder_done = 0;
      adder_res  = '0;
      m_cnt = 0;
      m_hold = 0;
      m_res = '0;
      forever begin
         @(negedge clk);
         #1;
         if (reset) begin
            m_cnt = 0;
            m_hold = 0;
         end else begin
            if (m_hold > 0) m_hold--;
            if (m_cnt > 0) begin
               m_cnt--;
               if (m_cnt == 0 && !model_stuck) begin
                  adder_res = m_res;
                  m_hold = 2;
               end
            end
            if (adder_start) begin
               m_res = ref_op(adder_sub, adder_a, adder_b);
               adder_res = {1'b1, rand_wide()};
               m_cnt = model_delay;
            end
         end
         adder_done = (m_hold > 0) || inj_done;
      end
   end

   // Drives one request and watches until two cycles past its ack (or a cycle budget).
   task automatic run_op(input int port, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W:0] r, output logic e, output logic e_start,
                         output int acks, output int others, output int starts,
                         output int start_t, output int ack_t);
      int t;
      acks = 0; others = 0; starts = 0; start_t = -1; ack_t = -1;
      r = '0; e = 0; e_start = 0; t = 0;
      if (port == 0) begin sub0 = s; a0 = a; b0 = b; req0 = 1; end
      else begin sub1 = s; a1 = a; b1 = b; req1 = 1; end
      while (t < 60 && !(acks > 0 && t >= ack_t + 2)) begin
         @(negedge clk);
         t++;
         if (adder_start) begin
            starts++;
            if (start_t < 0) begin start_t = t; e_start = err; end
         end
         if (port == 0 ? ack0 : ack1) begin
            acks++;
            if (ack_t < 0) begin ack_t = t; r = res; e = err; end
            if (port == 0) req0 = 0; else req1 = 0;
         end
         if (port == 0 ? ack1 : ack0) others++;
      end
      req0 = 0;
      req1 = 0;
   endtask

   task automatic test_reset();
      reset = 1; req0 = 0; req1 = 0; sub0 = 0; sub1 = 0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      inj_done = 0; model_stuck = 0; model_delay = 4;
      repeat (3) @(negedge clk);
      tests++;
      if ({ack0, ack1, err, busy, adder_start, adder_sub} !== 6'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got %b expected 000000", {ack0, ack1, err, busy, adder_start, adder_sub});
      end
      tests++;
      if (res !== '0) begin fails++; $display("FAIL reset_res: got low128 %0h expected 0", res[127:0]); end
      tests++;
      if (adder_a !== '0 || adder_b !== '0) begin
         fails++;
         $display("FAIL reset_operands: got a=%0h b=%0h (low128) expected 0", adder_a[127:0], adder_b[127:0]);
      end
      reset = 0;
      repeat (2) @(negedge clk);
      tests++;
      if ({busy, adder_start, ack0, ack1} !== 4'b0) begin
         fails++;
         $display("FAIL reset_idle: got busy/start/ack0/ack1 %b expected 0000", {busy, adder_start, ack0, ack1});
      end
   endtask

   task automatic test_single(input int port, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W:0] exp_r);
      logic [W:0] r; logic e, es; int acks, others, starts, st, at;
      run_op(port, s, a, b, r, e, es, acks, others, starts, st, at);
      tests++;
      if (acks !== 1 || others !== 0 || starts !== 1) begin
         fails++;
         $display("FAIL single%0d_handshake: got acks=%0d other_acks=%0d starts=%0d expected 1/0/1", port, acks, others, starts);
      end
      // cycles counted inclusively from the IDLE cycle that sees req to the ack cycle
      tests++;
      if (at + 1 !== 7 || at - st !== 5) begin
         fails++;
         $display("FAIL single%0d_latency: got req->ack %0d start->ack %0d expected 7 and 5", port, at + 1, at - st);
      end
      tests++;
      if (r !== exp_r || e !== 1'b0) begin
         fails++;
         $display("FAIL single%0d_result: got res=%0h err=%b expected res=%0h err=0 (low128)", port, r[127:0], e, exp_r[127:0]);
      end
   endtask

   task automatic test_round_robin();
      int seq[4]; int ack_time[4]; int nack, starts, t, extra;
      logic done_last;
      logic [W:0] exp0, exp1;
      reset = 1;
      sub0 = 0; a0 = rand_wide(); b0 = rand_wide();
      sub1 = 1; a1 = rand_wide(); b1 = rand_wide();
      exp0 = ref_op(0, a0, b0);
      exp1 = ref_op(1, a1, b1);
      req0 = 1; req1 = 1;
      @(negedge clk);
      reset = 0;
      nack = 0; starts = 0; t = 0; extra = 0; done_last = 0;
      for (int i = 0; i < 4; i++) begin seq[i] = -1; ack_time[i] = -1; end
      while (t < 80 && !(nack >= 4 && t >= ack_time[3] + 4)) begin
         @(negedge clk);
         t++;
         if (adder_start) begin
            starts++;
            tests++;
            if (done_last !== 1'b0) begin fails++; $display("FAIL rr_start_during_done: got start with done=1 expected done=0"); end
         end
         if (ack0 || ack1) begin
            if (nack < 4) begin
               seq[nack] = ack1 ? 1 : 0;
               ack_time[nack] = t;
               tests++;
               if (res !== (ack1 ? exp1 : exp0) || err !== 1'b0 || (ack0 && ack1)) begin
                  fails++;
                  $display("FAIL rr_result: got res=%0h err=%b ack0=%b ack1=%b (low128) expected correct single ack", res[127:0], err, ack0, ack1);
               end
            end else extra++;
            nack++;
            if (nack == 4) begin req0 = 0; req1 = 0; end
         end
         #2 done_last = adder_done;
      end
      req0 = 0; req1 = 0;
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (seq[i] !== i % 2) begin fails++; $display("FAIL rr_order[%0d]: got port %0d expected port %0d", i, seq[i], i % 2); end
      end
      for (int i = 1; i < 4; i++) begin
         tests++;
         if (ack_time[i] - ack_time[i-1] !== 8) begin
            fails++;
            $display("FAIL rr_throughput[%0d]: got %0d cycles between acks expected 8", i, ack_time[i] - ack_time[i-1]);
         end
      end
      tests++;
      if (starts !== 4 || extra !== 0) begin
         fails++;
         $display("FAIL rr_counts: got starts=%0d extra_acks=%0d expected 4 and 0", starts, extra);
      end
   endtask

   task automatic test_timeout();
      logic [W:0] r, ex; logic e, es; int acks, others, starts, st, at;
      logic [W-1:0] a, b;
      a = rand_wide(); b = rand_wide();
      model_stuck = 1;
      run_op(0, 0, a, b, r, e, es, acks, others, starts, st, at);
      model_stuck = 0;
      tests++;
      if (acks !== 1 || others !== 0) begin fails++; $display("FAIL to_acks: got acks=%0d other=%0d expected 1/0", acks, others); end
      tests++;
      if (at - st !== TO + 1) begin fails++; $display("FAIL to_latency: got start->ack %0d expected %0d", at - st, TO + 1); end
      tests++;
      if (r !== '0 || e !== 1'b1) begin fails++; $display("FAIL to_result: got res=%0h err=%b (low128) expected res=0 err=1", r[127:0], e); end

      a = rand_wide(); b = rand_wide(); ex = ref_op(1, a, b);
      run_op(1, 1, a, b, r, e, es, acks, others, starts, st, at);
      tests++;
      if (es !== 1'b0) begin fails++; $display("FAIL to_err_clear_on_grant: got err=%b at start expected 0", es); end
      tests++;
      if (r !== ex || e !== 1'b0 || acks !== 1) begin
         fails++;
         $display("FAIL to_recover: got res=%0h err=%b acks=%0d (low128) expected res=%0h err=0 acks=1", r[127:0], e, acks, ex[127:0]);
      end

      // done landing on the very cycle the watchdog expires still counts as success
      model_delay = TO;
      a = rand_wide(); b = rand_wide(); ex = ref_op(0, a, b);
      run_op(0, 0, a, b, r, e, es, acks, others, starts, st, at);
      tests++;
      if (r !== ex || e !== 1'b0 || at - st !== TO + 1) begin
         fails++;
         $display("FAIL to_done_wins: got res=%0h err=%b lat=%0d (low128) expected res=%0h err=0 lat=%0d", r[127:0], e, at - st, ex[127:0], TO + 1);
      end

      model_delay = TO + 1;
      a = rand_wide(); b = rand_wide();
      run_op(1, 0, a, b, r, e, es, acks, others, starts, st, at);
      tests++;
      if (r !== '0 || e !== 1'b1 || acks !== 1 || at - st !== TO + 1) begin
         fails++;
         $display("FAIL to_late_done: got res=%0h err=%b acks=%0d lat=%0d (low128) expected 0/1/1/%0d", r[127:0], e, acks, at - st, TO + 1);
      end
      model_delay = 4;
   endtask

   task automatic test_stray_done();
      logic [W:0] r, ex, held; logic e, es; int acks, others, starts, st, at, bad;
      logic [W-1:0] a, b;
      model_delay = TO + 2;
      a = rand_wide(); b = rand_wide();
      run_op(0, 0, a, b, r, e, es, acks, others, starts, st, at);
      model_delay = 4;
      tests++;
      if (r !== '0 || e !== 1'b1) begin fails++; $display("FAIL stray_setup: got res=%0h err=%b expected 0/1", r[127:0], e); end
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (ack0 || ack1 || busy || adder_start || res !== '0) bad++;
      end
      tests++;
      if (bad !== 0) begin fails++; $display("FAIL stray_guard_done: got %0d disturbed cycles expected 0", bad); end

      a = rand_wide(); b = rand_wide(); ex = ref_op(1, a, b);
      run_op(1, 1, a, b, r, e, es, acks, others, starts, st, at);
      held = res;
      inj_done = 1;
      bad = 0;
      repeat (2) begin
         @(negedge clk);
         if (ack0 || ack1 || busy || adder_start || res !== held) bad++;
      end
      tests++;
      if (bad !== 0 || held !== ex) begin fails++; $display("FAIL stray_idle_done: got %0d disturbed cycles expected 0", bad); end

      sub0 = 0; a0 = rand_wide(); b0 = rand_wide(); req0 = 1;
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (busy || adder_start) bad++;
      end
      tests++;
      if (bad !== 0) begin fails++; $display("FAIL stray_no_grant_while_done: got %0d busy cycles expected 0", bad); end
      inj_done = 0;
      a = a0; b = b0; ex = ref_op(0, a, b);
      run_op(0, 0, a, b, r, e, es, acks, others, starts, st, at);
      tests++;
      if (r !== ex || e !== 1'b0 || acks !== 1 || at !== 6) begin
         fails++;
         $display("FAIL stray_after: got res=%0h err=%b acks=%0d ack_cycle=%0d (low128) expected res=%0h 0/1/6", r[127:0], e, acks, at, ex[127:0]);
      end
   endtask

   task automatic test_reset_mid();
      logic [W:0] r, ex; logic e, es; int acks, others, starts, st, at, t, bad;
      logic [W-1:0] a, b;
      model_delay = 10;
      sub0 = 1; a0 = rand_wide(); b0 = rand_wide(); req0 = 1;
      t = 0;
      while (t < 10 && !adder_start) begin @(negedge clk); t++; end
      tests++;
      if (!adder_start) begin fails++; $display("FAIL mid_start: got no adder_start expected one within 10 cycles"); end
      repeat (2) @(negedge clk);
      reset = 1;
      req0 = 0;
      @(negedge clk);
      tests++;
      if ({ack0, ack1, err, busy, adder_start, adder_sub} !== 6'b0 || res !== '0 || adder_a !== '0 || adder_b !== '0) begin
         fails++;
         $display("FAIL mid_reset_clear: got ctrl=%b res=%0h a=%0h (low128) expected all 0",
                  {ack0, ack1, err, busy, adder_start, adder_sub}, res[127:0], adder_a[127:0]);
      end
      bad = 0;
      @(negedge clk);
      reset = 0;
      model_delay = 4;
      repeat (15) begin
         @(negedge clk);
         if (ack0 || ack1 || busy) bad++;
      end
      tests++;
      if (bad !== 0) begin fails++; $display("FAIL mid_no_ack: got %0d ack/busy cycles expected 0", bad); end
      a = rand_wide(); b = rand_wide(); ex = ref_op(1, a, b);
      run_op(1, 1, a, b, r, e, es, acks, others, starts, st, at);
      tests++;
      if (r !== ex || e !== 1'b0 || acks !== 1 || at !== 6) begin
         fails++;
         $display("FAIL mid_after_reset: got res=%0h err=%b acks=%0d ack_cycle=%0d (low128) expected res=%0h 0/1/6", r[127:0], e, acks, at, ex[127:0]);
      end
   endtask

   task automatic test_random();
      localparam int N = 40;
      bit pend[2]; int gap[2]; int waits[2];
      logic [W:0] expv[2];
      logic [W-1:0] na, nb; logic ns, ackp, done_last;
      int issued, served, cyc;
      pend = '{0, 0}; gap = '{0, 0}; waits = '{0, 0};
      issued = 0; served = 0; cyc = 0; done_last = 0;
      while ((served < N || pend[0] || pend[1]) && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         model_delay = $urandom_range(1, TO);
         if (adder_start) begin
            tests++;
            if (done_last !== 1'b0) begin fails++; $display("FAIL rand_start_during_done: got start with done=1 expected done=0"); end
         end
         for (int p = 0; p < 2; p++) begin
            ackp = (p == 0) ? ack0 : ack1;
            if (ackp) begin
               tests++;
               if (!pend[p]) begin
                  fails++;
                  $display("FAIL rand_unexpected_ack: got ack on port %0d expected none", p);
               end else if (res !== expv[p] || err !== 1'b0) begin
                  fails++;
                  $display("FAIL rand_result: port %0d got res=%0h err=%b (low128) expected res=%0h err=0", p, res[127:0], err, expv[p][127:0]);
               end
               if (pend[1-p]) begin
                  waits[1-p]++;
                  tests++;
                  if (waits[1-p] > 1) begin
                     fails++;
                     $display("FAIL rand_fairness: port %0d got passed over %0d times expected at most 1", 1 - p, waits[1-p]);
                  end
               end
               pend[p] = 0;
               served++;
               gap[p] = $urandom_range(0, 10);
               if (p == 0) req0 = 0; else req1 = 0;
            end
         end
         for (int p = 0; p < 2; p++) begin
            if (!pend[p]) begin
               if (gap[p] > 0) gap[p]--;
               else if (issued < N) begin
                  case ($urandom_range(0, 3))
                     0: begin na = '1; nb = rand_wide(); end
                     1: begin na = W'($urandom_range(0, 255)); nb = W'($urandom_range(0, 255)); end
                     default: begin na = rand_wide(); nb = rand_wide(); end
                  endcase
                  ns = 1'($urandom_range(0, 1));
                  expv[p] = ref_op(ns, na, nb);
                  pend[p] = 1;
                  waits[p] = 0;
                  issued++;
                  if (p == 0) begin sub0 = ns; a0 = na; b0 = nb; req0 = 1; end
                  else begin sub1 = ns; a1 = na; b1 = nb; req1 = 1; end
               end
            end
         end
         #2 done_last = adder_done;
      end
      req0 = 0; req1 = 0;
      model_delay = 4;
      tests++;
      if (served !== N || cyc >= 3000) begin
         fails++;
         $display("FAIL rand_complete: got %0d served in %0d cycles expected %0d", served, cyc, N);
      end
   endtask

   initial begin
      logic [W-1:0] op_a, op_b;
      logic [W:0] exp_r;
      tests = 0;
      fails = 0;
      reset = 1; inj_done = 0; model_stuck = 0; model_delay = 4;
      req0 = 0; req1 = 0; sub0 = 0; sub1 = 0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      test_reset();
      op_a = 5; op_b = 7; exp_r = 12;
      test_single(0, 1'b0, op_a, op_b, exp_r);
      op_a = 3; op_b = 5; exp_r = '1; exp_r = exp_r - 1;
      test_single(1, 1'b1, op_a, op_b, exp_r);
      test_round_robin();
      test_timeout();
      test_stray_done();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
